// File: rtl/uart_rx_dma.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_dma
//  Function : Drains received bytes from the UART slave port and packs them
//             two per word into a 16-bit memory ring buffer. The consumer
//             read pointer throttles the engine: while the ring is full, the
//             bytes stay in the UART RX FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_dma #(
    parameter logic [15:0] BASE_ADDR  = 16'h8000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [DEPTH_LOG2-1:0] i_rd_ptr,
    output logic [DEPTH_LOG2-1:0] o_wr_ptr,
    output logic                  o_pending,
    output logic                  o_int,
    input  logic [7:0]            i_slave_data,
    output logic                  o_slave_addr,
    input  logic                  i_slave_ack,
    output logic                  o_slave_we,
    output logic                  o_slave_cs,
    input  logic [15:0]           i_mem_data,
    output logic [15:0]           o_mem_data,
    output logic [15:0]           o_mem_addr,
    input  logic                  i_mem_ack,
    output logic                  o_mem_we,
    output logic                  o_mem_cs
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_STATUS      = 3'd1,
        S_EVAL        = 3'd2,
        S_READ        = 3'd3,
        S_WRITE       = 3'd4,
        S_WRITE_FLUSH = 3'd5
    } state_t;

    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic                  r_rx_empty;     // status bit0 from the last status poll
    logic [7:0]            r_low;          // held low byte of the next word
    logic                  r_flush_req;    // latched flush request
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic                  r_pending;
    logic                  r_int;
    logic                  r_slave_cs;
    logic                  r_slave_addr;
    logic                  r_mem_cs;
    logic                  r_mem_we;
    logic [15:0]           r_mem_addr;
    logic [15:0]           r_mem_data;

    logic [DEPTH_LOG2-1:0] w_wr_ptr_next;
    logic                  w_ring_full;
    logic [15:0]           w_wr_addr;
    logic                  w_unused;

    // One slot always stays empty so that full and empty are distinguishable
    assign w_wr_ptr_next = r_wr_ptr + c_PTR_ONE;
    assign w_ring_full   = (w_wr_ptr_next == i_rd_ptr);
    assign w_wr_addr     = BASE_ADDR + {{(16-DEPTH_LOG2){1'b0}}, r_wr_ptr};

    // Memory read data is never consumed by a write-only master
    assign w_unused = ^i_mem_data;

    // Engine state machine with all bus outputs registered on state entry
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_rx_empty   <= 1'b1;
            r_low        <= 8'h00;
            r_flush_req  <= 1'b0;
            r_wr_ptr     <= '0;
            r_pending    <= 1'b0;
            r_int        <= 1'b0;
            r_slave_cs   <= 1'b0;
            r_slave_addr <= 1'b0;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_mem_data   <= 16'h0000;
        end else begin
            r_int <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A pending flush wins over a new poll
                    if (r_flush_req && r_pending && !w_ring_full) begin
                        r_state    <= S_WRITE_FLUSH;
                        r_mem_cs   <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_wr_addr;
                        r_mem_data <= {8'h00, r_low};
                    end else begin
                        if (r_flush_req && !r_pending) begin
                            r_flush_req <= 1'b0;
                        end
                        if (i_enable) begin
                            r_state      <= S_STATUS;
                            r_slave_cs   <= 1'b1;
                            r_slave_addr <= 1'b0;
                        end
                    end
                end
                S_STATUS: begin
                    if (i_slave_ack) begin
                        r_rx_empty <= i_slave_data[0];
                        r_slave_cs <= 1'b0;
                        r_state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // A first byte can always be held; a second needs a free slot
                    if (!r_rx_empty && (!r_pending || !w_ring_full)) begin
                        r_state      <= S_READ;
                        r_slave_cs   <= 1'b1;
                        r_slave_addr <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (i_slave_ack) begin
                        r_slave_cs   <= 1'b0;
                        r_slave_addr <= 1'b0;
                        if (!r_pending) begin
                            r_low     <= i_slave_data;
                            r_pending <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state    <= S_WRITE;
                            r_mem_cs   <= 1'b1;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= w_wr_addr;
                            r_mem_data <= {i_slave_data, r_low};
                        end
                    end
                end
                S_WRITE, S_WRITE_FLUSH: begin
                    if (i_mem_ack) begin
                        r_mem_cs   <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= 16'h0000;
                        r_mem_data <= 16'h0000;
                        r_wr_ptr   <= w_wr_ptr_next;
                        r_pending  <= 1'b0;
                        r_int      <= 1'b1;
                        r_state    <= S_IDLE;
                        if (r_state == S_WRITE_FLUSH) begin
                            r_flush_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // A new flush request is latched on any cycle and beats a clear
            if (i_flush) begin
                r_flush_req <= 1'b1;
            end
        end
    end

    assign o_wr_ptr     = r_wr_ptr;
    assign o_pending    = r_pending;
    assign o_int        = r_int;
    assign o_slave_addr = r_slave_addr;
    assign o_slave_we   = 1'b0;
    assign o_slave_cs   = r_slave_cs;
    assign o_mem_data   = r_mem_data;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_we     = r_mem_we;
    assign o_mem_cs     = r_mem_cs;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_dma
//  Function : Self-checking bench for uart_rx_dma with a UART FIFO model,
//             a memory model and a byte-stream reference for packed words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_dma;

    localparam int          DL   = 2;
    localparam int          RING = 4;
    localparam logic [15:0] BASE = 16'h8000;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic          i_flush;
    logic [DL-1:0] i_rd_ptr;
    logic [DL-1:0] o_wr_ptr;
    logic          o_pending;
    logic          o_int;
    logic [7:0]    i_slave_data;
    logic          o_slave_addr;
    logic          i_slave_ack;
    logic          o_slave_we;
    logic          o_slave_cs;
    logic [15:0]   i_mem_data;
    logic [15:0]   o_mem_data;
    logic [15:0]   o_mem_addr;
    logic          i_mem_ack;
    logic          o_mem_we;
    logic          o_mem_cs;

    uart_rx_dma #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
        .i_rd_ptr(i_rd_ptr), .o_wr_ptr(o_wr_ptr), .o_pending(o_pending), .o_int(o_int),
        .i_slave_data(i_slave_data), .o_slave_addr(o_slave_addr), .i_slave_ack(i_slave_ack),
        .o_slave_we(o_slave_we), .o_slave_cs(o_slave_cs), .i_mem_data(i_mem_data),
        .o_mem_data(o_mem_data), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .o_mem_we(o_mem_we), .o_mem_cs(o_mem_cs)
    );

    always #5 i_clk = ~i_clk;

    // Environment and reference state
    logic [7:0]  fifo[$];       // UART RX FIFO contents
    logic [7:0]  unpaired[$];   // bytes popped but not yet seen in memory
    int          wcount, icount, scs_count, viol;
    logic        int_exp, flush_armed;
    logic [15:0] last_addr, last_data;
    bit          rd_gate = 1'b1, mem_gate = 1'b1;
    logic [7:0]  slv_data = 8'h00;
    int          checks = 0, failures = 0;
    logic [15:0] mon_ea, mon_ed;
    int          mon_occ;

    assign i_slave_ack  = o_slave_cs & (~o_slave_addr | rd_gate);
    assign i_mem_ack    = o_mem_cs & mem_gate;
    assign i_slave_data = slv_data;
    assign i_mem_data   = 16'h0000;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic model_clear();
        fifo.delete();
        unpaired.delete();
        wcount = 0; icount = 0; int_exp = 1'b0; flush_armed = 1'b0;
        last_addr = 16'h0; last_data = 16'h0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        model_clear();
        tick(2);
        i_reset = 1'b0;
        tick(1);
    endtask

    // Monitor: slave/memory models and end-to-end byte stream checking
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_int !== 1'b0 || int_exp) chk("int_pulse", o_int, int_exp);
            if (o_int === 1'b1) icount++;
            int_exp = 1'b0;
            if (o_slave_cs) scs_count++;
            if (o_slave_cs && o_mem_cs) viol++;
            if (o_slave_cs && o_slave_addr && fifo.size() == 0) viol++;
            if (o_mem_cs && o_mem_we && i_mem_ack) begin
                mon_ea  = BASE + 16'(wcount % RING);
                mon_occ = ((wcount % RING) - int'(i_rd_ptr) + RING) % RING;
                chk("ring_has_space", mon_occ <= RING - 2, 1);
                if (unpaired.size() >= 2) begin
                    mon_ed = {unpaired[1], unpaired[0]};
                    void'(unpaired.pop_front());
                    void'(unpaired.pop_front());
                end else if (unpaired.size() == 1 && flush_armed) begin
                    mon_ed = {8'h00, unpaired[0]};
                    void'(unpaired.pop_front());
                    flush_armed = 1'b0;
                end else begin
                    mon_ed = 16'hxxxx;
                end
                chk("mem_write", {o_mem_addr, o_mem_data}, {mon_ea, mon_ed});
                last_addr = o_mem_addr;
                last_data = o_mem_data;
                wcount++;
                int_exp = 1'b1;
            end
            if (o_slave_cs) begin
                if (o_slave_addr) slv_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
                else slv_data = {5'b00000, 1'b1, fifo.size() >= 16, fifo.size() == 0};
                if (o_slave_addr && i_slave_ack && fifo.size() > 0)
                    unpaired.push_back(fifo.pop_front());
            end
        end
    end

    typedef struct {
        bit          rst;
        int          push_n;
        logic [7:0]  first;
        logic [1:0]  rd;
        bit          en;
        bit          flush;
        int          wait_cyc;
        logic [1:0]  exp_wr;
        bit          exp_pend;
        int          exp_fifo;
        int          exp_writes;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
    } step_t;

    step_t steps[7];
    int    pushed, scs_snap;

    initial begin
        // rst push first  rd en fl wait | wr pend fifo writes addr data
        steps[0] = '{1'b1, 2, 8'h41, 2'd0, 1'b1, 1'b0, 20, 2'd1, 1'b0, 0, 1, 16'h8000, 16'h4241};
        steps[1] = '{1'b0, 1, 8'h55, 2'd0, 1'b1, 1'b0, 20, 2'd1, 1'b1, 0, 1, 16'h8000, 16'h4241};
        steps[2] = '{1'b0, 0, 8'h00, 2'd0, 1'b1, 1'b1, 20, 2'd2, 1'b0, 0, 2, 16'h8001, 16'h0055};
        steps[3] = '{1'b0, 0, 8'h00, 2'd0, 1'b1, 1'b1, 20, 2'd2, 1'b0, 0, 2, 16'h8001, 16'h0055};
        steps[4] = '{1'b1, 8, 8'h10, 2'd0, 1'b1, 1'b0, 80, 2'd3, 1'b1, 1, 3, 16'h8002, 16'h1514};
        steps[5] = '{1'b0, 0, 8'h00, 2'd1, 1'b1, 1'b0, 20, 2'd0, 1'b0, 0, 4, 16'h8003, 16'h1716};
        steps[6] = '{1'b0, 2, 8'h60, 2'd1, 1'b0, 1'b0, 20, 2'd0, 1'b0, 2, 4, 16'h8003, 16'h1716};

        viol = 0; scs_count = 0;
        model_clear();
        i_reset = 1'b1; i_enable = 1'b0; i_flush = 1'b0; i_rd_ptr = '0;
        #1;
        chk("reset_mem_outs", {o_mem_cs, o_mem_we, o_mem_addr, o_mem_data}, 34'd0);
        chk("reset_slave_outs", {o_slave_cs, o_slave_we, o_slave_addr}, 3'd0);
        chk("reset_status", {o_wr_ptr, o_pending, o_int}, 4'd0);
        tick(2);
        i_reset = 1'b0;
        tick(1);

        // Directed table
        for (int s = 0; s < 7; s++) begin
            if (steps[s].rst) do_reset();
            i_rd_ptr = steps[s].rd;
            i_enable = steps[s].en;
            tick(5);
            for (int b = 0; b < steps[s].push_n; b++) fifo.push_back(steps[s].first + 8'(b));
            if (steps[s].flush) begin
                flush_armed = 1'b1;
                i_flush = 1'b1;
                tick(1);
                i_flush = 1'b0;
            end
            tick(steps[s].wait_cyc);
            chk($sformatf("step%0d_wr_ptr", s), o_wr_ptr, steps[s].exp_wr);
            chk($sformatf("step%0d_pending", s), o_pending, steps[s].exp_pend);
            chk($sformatf("step%0d_fifo_left", s), fifo.size(), steps[s].exp_fifo);
            chk($sformatf("step%0d_writes", s), wcount, steps[s].exp_writes);
            chk($sformatf("step%0d_last_addr", s), last_addr, steps[s].exp_addr);
            chk($sformatf("step%0d_last_data", s), last_data, steps[s].exp_data);
        end

        // Memory ack held off for 5 cycles: write must be held stable
        do_reset();
        i_rd_ptr = '0; i_enable = 1'b1; mem_gate = 1'b0;
        fifo.push_back(8'hA1); fifo.push_back(8'hA2);
        for (int i = 0; i < 50 && !o_mem_cs; i++) tick(1);
        chk("delay_write_started", o_mem_cs, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("delay_hold", {o_mem_cs, o_mem_we, o_mem_addr, o_mem_data, o_slave_cs, o_int},
                {1'b1, 1'b1, 16'h8000, 16'hA2A1, 1'b0, 1'b0});
            tick(1);
        end
        mem_gate = 1'b1;
        tick(3);
        chk("delay_int_count", icount, 1);
        chk("delay_wr_ptr", o_wr_ptr, 2'd1);

        // Drop enable while a data read is outstanding
        do_reset();
        i_enable = 1'b1; rd_gate = 1'b0;
        fifo.push_back(8'hB0); fifo.push_back(8'hB1);
        for (int i = 0; i < 50 && !(o_slave_cs && o_slave_addr); i++) tick(1);
        chk("endrop_in_read", {o_slave_cs, o_slave_addr}, 2'b11);
        i_enable = 1'b0; rd_gate = 1'b1;
        tick(1);
        scs_snap = scs_count;
        tick(30);
        chk("endrop_no_cs", scs_count, scs_snap);
        chk("endrop_pending", o_pending, 1'b1);
        chk("endrop_fifo", fifo.size(), 1);
        i_enable = 1'b1;
        tick(30);
        chk("endrop_resume_data", last_data, 16'hB1B0);

        // Asynchronous reset in the middle of a write
        do_reset();
        i_enable = 1'b1; mem_gate = 1'b0;
        fifo.push_back(8'hC0); fifo.push_back(8'hC1);
        for (int i = 0; i < 50 && !o_mem_cs; i++) tick(1);
        chk("rstw_write_started", o_mem_cs, 1'b1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("rstw_mem_outs", {o_mem_cs, o_mem_we, o_mem_addr, o_mem_data}, 34'd0);
        chk("rstw_other_outs", {o_slave_cs, o_slave_addr, o_slave_we, o_int, o_pending, o_wr_ptr}, 7'd0);
        model_clear();
        mem_gate = 1'b1;
        tick(2);
        i_reset = 1'b0;
        tick(1);

        // Randomized traffic with random waits and a random consumer
        do_reset();
        i_enable = 1'b1; i_rd_ptr = '0; pushed = 0;
        for (int c = 0; c < 4000 && !(pushed == 40 && wcount == 20); c++) begin
            rd_gate  = ($urandom % 4) != 0;
            mem_gate = ($urandom % 3) != 0;
            if (pushed < 40 && fifo.size() < 16 && ($urandom % 3) == 0) begin
                fifo.push_back(8'($urandom));
                pushed++;
            end
            if (((wcount % RING) - int'(i_rd_ptr) + RING) % RING > 0 && ($urandom % 5) == 0)
                i_rd_ptr = i_rd_ptr + 2'd1;
            tick(1);
        end
        rd_gate = 1'b1; mem_gate = 1'b1;
        tick(3);
        chk("rand_words", wcount, 20);
        chk("rand_ints", icount, 20);
        chk("rand_wr_ptr", o_wr_ptr, 2'd0);
        chk("rand_pending", o_pending, 1'b0);
        chk("rand_fifo_drained", fifo.size(), 0);
        chk("protocol_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_dma.md
# uart_rx_dma

Receive-side DMA engine that drains host bytes from the UART master/slave block's 8-bit slave port and stores them, packed two per word, into a ring buffer in 16-bit system memory. It sits directly downstream of the UART block's RX FIFO and replaces CPU polling of the rx/tx register. It also sits upstream of the memory bus arbiter as an additional bus master. A consumer read pointer provides backpressure: bytes stay in the UART RX FIFO while the ring is full.

## Interface
Parameters:
- BASE_ADDR, 16'h8000, word address of ring slot 0
- DEPTH_LOG2, 4, ring holds 2**DEPTH_LOG2 words; range 2..8

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  level; 1 = engine may start new slave reads
- i_flush  in  1  pulse; write a pending lone byte out with high byte 8'h00
- i_rd_ptr  in  DEPTH_LOG2  consumer read pointer, in words
- o_wr_ptr  out  DEPTH_LOG2  producer write pointer: next slot to be written
- o_pending  out  1  one low byte is held and not yet written
- o_int  out  1  one-cycle pulse per completed word write
- i_slave_data  in  8  data from the UART slave port
- o_slave_addr  out  1  0 = status, 1 = rx data
- i_slave_ack  in  1  slave acknowledge
- o_slave_we  out  1  always 0
- o_slave_cs  out  1  slave select
- i_mem_data  in  16  unused; read data from the memory bus
- o_mem_data  out  16  write data
- o_mem_addr  out  16  word address
- i_mem_ack  in  1  memory acknowledge
- o_mem_we  out  1  write enable
- o_mem_cs  out  1  memory select

## Operation
- Slave status bits: bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full. The slave pops an RX byte in the same cycle as a read of addr 1 with ack.
- ring_full = ((o_wr_ptr + 1) mod 2**DEPTH_LOG2 == i_rd_ptr). The ring is empty when the pointers are equal. One slot always stays unused.
- State machine:
  - IDLE → STATUS when i_enable=1.
  - IDLE → WRITE_FLUSH when a latched flush is set, o_pending=1 and !ring_full. A latched flush with o_pending=0 is cleared.
  - STATUS: o_slave_cs=1, o_slave_addr=0. On i_slave_ack, register the status and go to EVAL.
  - EVAL → READ when status bit0=0 and (o_pending=0 or !ring_full). Otherwise → IDLE.
  - READ: o_slave_cs=1, o_slave_addr=1. On ack, capture the byte:
    - if o_pending=0: store it as the low byte, set o_pending, go to IDLE;
    - if o_pending=1: form word {byte, low}, go to WRITE.
  - WRITE / WRITE_FLUSH: o_mem_cs=1, o_mem_we=1, o_mem_addr=BASE_ADDR+o_wr_ptr (zero-extended, 16-bit wrap).
    - o_mem_data = {byte, low} for WRITE, {8'h00, low} for WRITE_FLUSH.
    - Hold all outputs until i_mem_ack.
    - On the ack cycle: o_wr_ptr increments mod 2**DEPTH_LOG2, o_pending clears, o_int=1 for one cycle, go to IDLE.
- i_flush is latched on any cycle. The latch is cleared when WRITE_FLUSH completes, or when the check finds o_pending=0. Flush is checked in IDLE before i_enable.
- Dropping i_enable mid-transaction: the current state finishes normally, then the engine stays in IDLE. A pending byte is kept.
- Ring full with o_pending=1: the engine keeps polling status but never reads. Bytes accumulate in the UART RX FIFO, and none are lost.

## Timing
- Reset (async): state IDLE; o_wr_ptr=0, o_pending=0, o_int=0, flush latch=0.
- Reset values: all slave and memory outputs are 0 (cs, we, addr, data).
- Reset mid-write drops o_mem_cs immediately. The word is lost and the pointer stays 0.
- All outputs are registered or decoded from the state register only; no combinational path from i_* to o_*_cs.
- With a zero-wait slave (ack = cs), one byte costs 4 cycles: IDLE, STATUS, EVAL, READ.
- A second byte plus a 0-wait memory write costs 5 cycles. The write cs asserts the cycle after the READ ack.
- o_int asserts in the cycle after the i_mem_ack cycle and lasts exactly 1 cycle.
- o_wr_ptr and o_pending update in the same cycle as the o_int pulse.
- i_rd_ptr is sampled only in IDLE and EVAL. A change during WRITE takes effect on the next decision.

## Test plan
- Reset, enable, UART FIFO supplies 0x41 then 0x42 → one write of 16'h4241 to 16'h8000; o_wr_ptr=1; one o_int pulse; the status-read/data-read sequence on the slave port is correct.
- One byte 0x55 then i_flush → o_pending=1 after the read; after the flush, write 16'h0055 to 16'h8000; o_pending=0; a flush with nothing pending produces no write.
- DEPTH_LOG2=2, i_rd_ptr=0, 8 bytes supplied → 3 words written (o_wr_ptr=3), 7th byte held pending, 8th left in the FIFO. Set i_rd_ptr=1 → 4th word written to 16'h8003 and o_wr_ptr wraps to 0.
- Memory ack delayed 5 cycles → address and data held stable, no slave access meanwhile, a single o_int pulse.
- Drop i_enable during READ → the byte is captured, then no further slave cs while the FIFO stays non-empty.
- Assert i_reset during WRITE → o_mem_cs falls without a clock edge; all outputs return to their reset values.
